// File: rtl/video_in_pkg.sv
// Shared types and constants for the video_in blocks.
//   state_e  : store-side FSM states (FILL gathers pixels, BURST writes them out)
//   CTI_*    : Wishbone cycle-type identifiers used by burst masters
package video_in_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [2:0] CTI_IDLE = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

endpackage

// File: rtl/video_in_pack.sv
// Byte-to-word packer: four pixels form one little-endian 32-bit word.
//   clk, nRST    : clock, asynchronous active-low reset
//   clr          : drop any partial word; a byte presented together is stored as byte 0
//   byte_valid   : byte_in is captured this cycle
//   byte_in      : pixel byte
//   byte_idx     : number of bytes held in the partial word (registered)
//   word_valid_c : this cycle's byte completes a word (combinational)
//   word_c       : completed word, valid with word_valid_c (combinational)
module video_in_pack (
  input  logic        clk,
  input  logic        nRST,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic        word_valid_c,
  output logic [31:0] word_c
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] part_q, part_d;
  logic [1:0]  pos;

  // Slot for the incoming byte; a clear restarts packing at slot 0.
  always_comb begin
    idx_d        = idx_q;
    part_d       = part_q;
    word_valid_c = 1'b0;
    pos          = clr ? 2'd0 : idx_q;
    if (clr) idx_d = 2'd0;
    if (byte_valid) begin
      idx_d = pos + 2'd1;
      case (pos)
        2'd0:    part_d[7:0]   = byte_in;
        2'd1:    part_d[15:8]  = byte_in;
        2'd2:    part_d[23:16] = byte_in;
        default: word_valid_c  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      idx_q  <= 2'd0;
      part_q <= 24'd0;
    end else begin
      idx_q  <= idx_d;
      part_q <= part_d;
    end
  end

  assign word_c   = {byte_in, part_q};
  assign byte_idx = idx_q;

endmodule

// File: rtl/video_in_store.sv
// Pops pixels from the video input FIFO, packs them into words, gathers
// BURST_LEN words and writes them to the frame buffer as one Wishbone
// classic incrementing burst. Owns the frame-buffer address; pulses
// frame_done after the last burst of a frame is acknowledged.
//   clk, nRST                        : clock, asynchronous active-low reset
//   fifo_data, fifo_empty, fifo_r_e  : FIFO read port (1-cycle read latency)
//   frame_start                      : start-of-frame pulse, resynchronises addressing
//   wb_*                             : Wishbone master write port
//   frame_done                       : one-cycle end-of-frame pulse
module video_in_store
  import video_in_pkg::*;
#(
  parameter logic [31:0] FRAME_BASE = 32'h0040_0000,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_r_e,
  input  logic        frame_start,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  input  logic        wb_ack_i,
  output logic        frame_done
);

  localparam int unsigned BEAT_W      = $clog2(BURST_LEN);
  localparam int unsigned FILL_BYTES  = 4 * BURST_LEN;
  localparam int unsigned CNT_W       = $clog2(FILL_BYTES) + 1;
  localparam int unsigned FRAME_WORDS = IMG_WIDTH * IMG_HEIGHT / 4;
  localparam int unsigned FWC_W       = $clog2(FRAME_WORDS + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [31:0]       BURST_BYTES = 32'(FILL_BYTES);
  localparam logic [FWC_W-1:0]  LAST_BURST  = FWC_W'(FRAME_WORDS - BURST_LEN);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   word_idx_q, word_idx_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, beat_nxt;
  logic [31:0]         base_q, base_d;
  logic [FWC_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                resync_q, resync_d;
  logic                inflight_q, inflight_d;
  logic [31:0]         wbuf_q [BURST_LEN];
  logic [31:0]         wbuf_d [BURST_LEN];
  logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, done_q, done_d;
  logic [31:0]         adr_q, adr_d, dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic [2:0]          cti_q, cti_d;

  logic [1:0]          byte_idx;
  logic                word_valid_c;
  logic [31:0]         word_c;
  logic                pack_clr, byte_valid;
  logic [CNT_W-1:0]    fill_lvl;

  assign pack_clr   = (state_q == FILL) && frame_start;
  assign byte_valid = (state_q == FILL) && inflight_q;

  video_in_pack u_pack (
    .clk          (clk),
    .nRST         (nRST),
    .clr          (pack_clr),
    .byte_valid   (byte_valid),
    .byte_in      (fifo_data),
    .byte_idx     (byte_idx),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Bytes held plus the byte still in flight must never exceed one burst.
  assign fill_lvl   = CNT_W'({word_idx_q, byte_idx}) + CNT_W'(inflight_q);
  assign fifo_r_e   = (state_q == FILL) && !fifo_empty && (fill_lvl < CNT_W'(FILL_BYTES));
  assign inflight_d = fifo_r_e;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    beat_d      = beat_q;
    base_d      = base_q;
    frame_cnt_d = frame_cnt_q;
    resync_d    = resync_q;
    wbuf_d      = wbuf_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    cti_d       = cti_q;
    done_d      = 1'b0;
    beat_nxt    = beat_q + BEAT_W'(1);

    if (state_q == FILL) begin
      if (frame_start) begin
        word_idx_d  = '0;
        base_d      = FRAME_BASE;
        frame_cnt_d = '0;
      end
      // word_valid_c is suppressed by the packer clear, so no conflict with frame_start.
      if (word_valid_c) begin
        wbuf_d[word_idx_q] = word_c;
        if (word_idx_q == LAST_BEAT) begin
          state_d    = BURST;
          word_idx_d = '0;
          beat_d     = '0;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          we_d       = 1'b1;
          sel_d      = 4'hF;
          adr_d      = base_q;
          dat_d      = wbuf_q[0];
          cti_d      = CTI_INCR;
        end else begin
          word_idx_d = word_idx_q + BEAT_W'(1);
        end
      end
    end else begin
      if (frame_start) resync_d = 1'b1;
      if (wb_ack_i) begin
        if (beat_q == LAST_BEAT) begin
          state_d  = FILL;
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = 4'h0;
          cti_d    = CTI_IDLE;
          adr_d    = 32'd0;
          dat_d    = 32'd0;
          resync_d = 1'b0;
          // A resync supersedes the natural wrap: one reload, no frame_done.
          if (resync_q || frame_start) begin
            base_d      = FRAME_BASE;
            frame_cnt_d = '0;
          end else if (frame_cnt_q == LAST_BURST) begin
            base_d      = FRAME_BASE;
            frame_cnt_d = '0;
            done_d      = 1'b1;
          end else begin
            base_d      = base_q + BURST_BYTES;
            frame_cnt_d = frame_cnt_q + FWC_W'(BURST_LEN);
          end
        end else begin
          beat_d = beat_nxt;
          adr_d  = base_q + 32'({beat_nxt, 2'b00});
          dat_d  = wbuf_q[beat_nxt];
          cti_d  = (beat_nxt == LAST_BEAT) ? CTI_END : CTI_INCR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= FILL;
      word_idx_q  <= '0;
      beat_q      <= '0;
      base_q      <= FRAME_BASE;
      frame_cnt_q <= '0;
      resync_q    <= 1'b0;
      inflight_q  <= 1'b0;
      wbuf_q      <= '{default: '0};
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      sel_q       <= 4'h0;
      cti_q       <= CTI_IDLE;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      frame_cnt_q <= frame_cnt_d;
      resync_q    <= resync_d;
      inflight_q  <= inflight_d;
      wbuf_q      <= wbuf_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cti_q       <= cti_d;
      done_q      <= done_d;
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_cti_o   = cti_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_video_in_store.sv
// Bench for video_in_store: FIFO source and Wishbone slave models, a
// byte-stream reference model that queues expected bus beats, and a
// monitor that checks every presented beat against that queue.
module tb_video_in_store;

  localparam logic [31:0] FB = 32'h0040_0000;
  localparam int unsigned BL = 8;
  localparam int unsigned IW = 32;
  localparam int unsigned IH = 4;
  localparam int unsigned FRAME_WORDS = IW * IH / 4;

  logic        clk = 1'b0;
  logic        nRST;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_r_e;
  logic        frame_start;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, frame_done;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pend[$];
  int n_cmp = 0;
  int n_bad = 0;

  // stimulus controls
  int   avail = 0;
  int   empty_mode = 0;   // 0 never empty, 1 toggle, 2 random
  int   ack_mode = 0;     // 0 always, 1 random, 2 stall beat 2 for 3 cycles
  bit   hole = 1'b0;
  bit   pop_now = 1'b0;
  logic [7:0] src = 8'h00;
  int   beat_cnt = 0;
  int   stall = 0;
  int   done_cnt = 0;

  // reference model state
  bit          m_burst = 1'b0;
  bit          m_resync = 1'b0;
  bit          exp_done = 1'b0;
  bit          re_prev = 1'b0;
  int          m_acks = 0;
  int          m_words = 0;
  logic [31:0] m_base = FB;

  always #5 clk = ~clk;

  video_in_store #(
    .FRAME_BASE (FB),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH),
    .BURST_LEN  (BL)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_r_e    (fifo_r_e),
    .frame_start (frame_start),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_cti_o    (wb_cti_o),
    .wb_ack_i    (wb_ack_i),
    .frame_done  (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO source: pops take effect at the edge, data appears right after it.
  always begin
    @(negedge clk);
    pop_now = nRST && fifo_r_e && !fifo_empty;
    @(posedge clk);
    #1;
    if (pop_now) begin
      fifo_data = src;
      src = src + 8'd1;
      avail--;
    end
    case (empty_mode)
      1:       hole = !hole;
      2:       hole = ($urandom_range(0, 2) == 0);
      default: hole = 1'b0;
    endcase
    fifo_empty = (avail == 0) || hole;
  end

  // Wishbone slave.
  always begin
    @(posedge clk);
    #1;
    if (wb_cyc_o && wb_stb_o) begin
      case (ack_mode)
        0:       wb_ack_i = 1'b1;
        1:       wb_ack_i = ($urandom_range(0, 2) != 0);
        default: wb_ack_i = !(beat_cnt == 2 && stall < 3);
      endcase
    end else begin
      wb_ack_i = 1'b0;
    end
    @(negedge clk);
    if (wb_stb_o && wb_ack_i) begin
      beat_cnt = (beat_cnt == BL - 1) ? 0 : beat_cnt + 1;
      stall = 0;
    end else if (wb_stb_o) begin
      stall++;
    end
    if (frame_done) done_cnt++;
  end

  // Reference model: decides, from the byte stream and bus handshakes,
  // what the DUT must show after the coming edge.
  always @(negedge clk) begin
    if (nRST) begin
      bit          cap;
      logic [7:0]  cap_byte;
      beat_t       e;
      chk("cyc_phase", 32'(wb_cyc_o), 32'(m_burst));
      chk("stb_phase", 32'(wb_stb_o), 32'(m_burst));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      exp_done = 1'b0;
      if (fifo_empty) chk("read_while_empty", 32'(fifo_r_e), 32'd0);
      if (m_burst)    chk("read_in_burst", 32'(fifo_r_e), 32'd0);
      cap      = re_prev;
      cap_byte = fifo_data;
      re_prev  = fifo_r_e && !fifo_empty;
      if (!m_burst) begin
        if (frame_start) begin
          pend.delete();
          m_base  = FB;
          m_words = 0;
        end
        if (cap) begin
          pend.push_back(cap_byte);
          if (pend.size() == 4 * BL) begin
            for (int b = 0; b < int'(BL); b++) begin
              e.adr = m_base + 32'(4 * b);
              e.dat = {pend[4*b+3], pend[4*b+2], pend[4*b+1], pend[4*b]};
              e.cti = (b == int'(BL) - 1) ? 3'b111 : 3'b010;
              exp_q.push_back(e);
            end
            pend.delete();
            m_burst  = 1'b1;
            m_acks   = 0;
            m_resync = 1'b0;
          end
        end
      end else begin
        if (frame_start) m_resync = 1'b1;
        if (wb_ack_i) begin
          m_acks++;
          if (m_acks == int'(BL)) begin
            m_burst = 1'b0;
            if (m_resync) begin
              m_base  = FB;
              m_words = 0;
            end else if (m_words + int'(BL) == int'(FRAME_WORDS)) begin
              m_base   = FB;
              m_words  = 0;
              exp_done = 1'b1;
            end else begin
              m_base  = m_base + 32'(4 * BL);
              m_words = m_words + int'(BL);
            end
          end
        end
      end
    end
  end

  // Monitor: every presented beat must match the head of the expectation queue.
  always @(negedge clk) begin
    if (nRST && wb_cyc_o && wb_stb_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", wb_adr_o, 32'hFFFF_FFFF);
      end else begin
        chk("adr", wb_adr_o, exp_q[0].adr);
        chk("dat", wb_dat_o, exp_q[0].dat);
        chk("cti", 32'(wb_cti_o), 32'(exp_q[0].cti));
        chk("sel", 32'(wb_sel_o), 32'hF);
        chk("we", 32'(wb_we_o), 32'd1);
        if (wb_ack_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic feed(input int n);
    avail = avail + n;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int quiet = 0;
    for (int i = 0; i < max_cyc && quiet < 4; i++) begin
      @(posedge clk);
      #2;
      if (avail == 0 && !wb_cyc_o && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    chk({"idle_", tag}, 32'(quiet >= 4), 32'd1);
  endtask

  task automatic pulse_fs();
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    int k;
    nRST        = 1'b0;
    fifo_data   = 8'h00;
    fifo_empty  = 1'b1;
    frame_start = 1'b0;
    wb_ack_i    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_fifo_r_e", 32'(fifo_r_e), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_cti", 32'(wb_cti_o), 32'd0);
    @(negedge clk);
    nRST = 1'b1;

    // bytes 0x00..0x1F, zero-wait slave
    feed(32);
    wait_idle(300, "basic");

    // slave stalls beat 2 for three cycles
    ack_mode = 2;
    feed(32);
    wait_idle(300, "stall");

    // frame_start after 13 bytes in FILL discards them
    ack_mode = 0;
    feed(13);
    wait_idle(100, "partial");
    pulse_fs();
    feed(32);
    wait_idle(300, "resync_fill");

    // frame_start during beat 4 of a burst
    feed(64);
    k = 0;
    while (k < 300) begin
      @(posedge clk);
      #1;
      if (wb_cyc_o && beat_cnt == 4) break;
      k++;
    end
    chk("reach_beat4", 32'(k < 300), 32'd1);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    wait_idle(400, "resync_burst");

    // one full frame plus one burst, random slave and FIFO gaps
    pulse_fs();
    done_cnt   = 0;
    ack_mode   = 1;
    empty_mode = 2;
    feed(4 * 4 * int'(FRAME_WORDS) / 4 + 32);
    wait_idle(2000, "frame");
    chk("frame_done_count", 32'(done_cnt), 32'd1);

    // FIFO empty toggling every other cycle
    ack_mode   = 0;
    empty_mode = 1;
    feed(64);
    wait_idle(800, "toggle");

    // random traffic with occasional frame_start
    ack_mode   = 1;
    empty_mode = 2;
    feed(600);
    k = 0;
    while (avail > 0 && k < 6000) begin
      @(posedge clk);
      #1;
      frame_start = ($urandom_range(0, 119) == 0);
      k++;
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    wait_idle(2000, "random");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
